pipe_mem_wb_buf: RTL and testbench
==================================

Name: pipe_mem_wb_buf

Overview:
Parametrised successor to the MEM/WB pipeline register. It carries up to NCH register-file writes per retiring instruction from the memory stage to write-back. It replaces the single-slot, busy-driven register with a DEPTH-entry elastic queue that uses a valid/ready handshake. It also adds flush, x0 write suppression, intra-entry write-conflict resolution and optional bubble dropping.

Parameters:
DATA_W, 32, write-data width per channel
ADDR_W, 5, register-index width per channel
NCH, 2, write channels per entry
DEPTH, 2, queue entries; power of two, >=2
DROP_EMPTY, 1, 1 = an accepted entry with no surviving write enables is discarded instead of stored
ZERO_REG, 1, 1 = writes to index 0 have their enable cleared at push

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; 0 freezes all state
flush_in  in  1  synchronous queue discard
mem_valid  in  1  memory stage presents an entry
mem_ready  out  1  queue can accept an entry
mem_we  in  NCH  per-channel write enable
mem_w_addr  in  NCH*ADDR_W  per-channel index; channel i is at [i*ADDR_W +: ADDR_W]
mem_w_data  in  NCH*DATA_W  per-channel data, packed the same way
wb_valid  out  1  head entry present
wb_ready  in  1  write-back consumes the head
wb_we  out  NCH  head write enables
wb_w_addr  out  NCH*ADDR_W  head indices
wb_w_data  out  NCH*DATA_W  head data
count  out  $clog2(DEPTH+1)  occupied entries
busy_out  out  1  count != 0

Behaviour:
- Reset (rst_in=0, asynchronous): count=0, read/write pointers=0, storage contents don't-care.
  - Outputs while in reset: wb_valid=0, wb_we=0, wb_w_addr=0, wb_w_data=0, mem_ready=1, busy_out=0.
- rdy_in=0: no push, no pop, no flush; registers hold.
  - mem_ready and wb_valid still reflect current state; handshakes occurring while rdy_in=0 do not count.
- Push: mem_valid & mem_ready & rdy_in & !flush_in.
  - mem_ready = (count != DEPTH). It is a function of registers only, with no combinational path from wb_ready.
- Pop: wb_valid & wb_ready & rdy_in & !flush_in.
  - wb_valid = (count != 0).
- Simultaneous push and pop: count unchanged; both pointers advance. When full, no push is possible in that cycle even if a pop occurs.
- Latency: a pushed entry appears at wb_* on the next rising edge. There is no same-cycle bypass.
- Head outputs come from registered storage at the read pointer. When count=0, wb_we, wb_w_addr and wb_w_data are forced to 0.
- Pointers are log2(DEPTH) bits and wrap naturally. count saturates logically at DEPTH via mem_ready.
- Write-enable filtering at push time, applied in this order:
  - (a) ZERO_REG=1: clear we[i] where addr[i]==0.
  - (b) Conflict: if we[i] and we[j] are set with j>i and addr[i]==addr[j], clear we[i]. The highest channel wins.
  - (c) DROP_EMPTY=1 and all filtered we bits are 0: the handshake completes (entry consumed), but nothing is stored and count is unchanged.
- Filtered addr/data are stored unchanged; only enables are modified.
- Flush (flush_in=1, rdy_in=1): count=0 and pointers=0 on the next edge. Flush has priority over a same-cycle push and pop; neither takes effect.
- Reset asserted mid-operation clears immediately, regardless of clk_in or rdy_in. Nothing else in the block is asynchronous.

Test Plan:
- Reset/latency: release rst_in, push {we=01, addr0=3, data0=0xDEADBEEF}, wb_ready=0 -> wb_valid=1 on the next cycle with that data, count=1; reset values are checked during rst_in=0.
- Fill/backpressure: DEPTH=2, wb_ready=0, push 3 entries with data 1, 2, 3 -> mem_ready=0 after the 2nd push, the 3rd is not accepted, count=2. Then set wb_ready=1 -> pops return 1 then 2; once space frees, the held 3rd entry is accepted (mem_valid kept high).
- Full with simultaneous pop: count=2, mem_valid=1, wb_ready=1 -> pop occurs, push rejected that cycle, count=1. Next cycle push+pop -> count stays 1; pointer wrap verified over 8 entries in order.
- Filtering: push {we=11, addr0=7, addr1=7, data0=0xA, data1=0xB} -> wb_we=10, data1=0xB. Push {we=01, addr0=0}, DROP_EMPTY=1 -> handshake completes, count unchanged, wb_valid stays 0.
- Flush priority: count=2, cycle with flush_in=1, mem_valid=1, wb_ready=1 -> next cycle count=0, wb_valid=0, wb_*=0, mem_ready=1; the pushed entry is not present.
- rdy_in freeze: count=1, rdy_in=0 for 3 cycles with mem_valid=1, wb_ready=1, flush_in=1 -> count, head and pointers unchanged. Assert rst_in=0 mid-freeze -> immediate clear without a clock edge.

Source files
------------

// File: rtl/pipe_mem_wb_buf.sv
// pipe_mem_wb_buf: elastic MEM/WB queue carrying up to NCH register writes
// per retiring instruction. The memory stage pushes with a valid/ready
// handshake and write-back pops the head. Write enables are filtered when an
// entry is pushed: x0 writes are suppressed, and when two channels hit the
// same index only the higher channel keeps its enable. An entry whose enables
// all end up cleared can optionally be dropped instead of stored.
module pipe_mem_wb_buf #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NCH        = 2,
  parameter int DEPTH      = 2,
  parameter int DROP_EMPTY = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [NCH-1:0]             mem_we,
  input  logic [NCH*ADDR_W-1:0]      mem_w_addr,
  input  logic [NCH*DATA_W-1:0]      mem_w_data,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [NCH-1:0]             wb_we,
  output logic [NCH*ADDR_W-1:0]      wb_w_addr,
  output logic [NCH*DATA_W-1:0]      wb_w_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Applies x0 suppression first, then conflict resolution; the
  // conflict pass only considers enables that survived the x0 pass.
  function automatic logic [NCH-1:0] filter_we(
    input logic [NCH-1:0]        we,
    input logic [NCH*ADDR_W-1:0] addr
  );
    logic [NCH-1:0] zero_s;
    logic [NCH-1:0] res_s;
    zero_s = we;
    if (ZERO_REG != 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (addr[i*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}}) begin
          zero_s[i] = 1'b0;
        end
      end
    end
    res_s = zero_s;
    for (int i = 0; i < NCH; i++) begin
      for (int j = i + 1; j < NCH; j++) begin
        if (zero_s[i] && zero_s[j] &&
            (addr[i*ADDR_W +: ADDR_W] == addr[j*ADDR_W +: ADDR_W])) begin
          res_s[i] = 1'b0;
        end
      end
    end
    return res_s;
  endfunction

  logic [NCH-1:0]        we_mem_r   [DEPTH];
  logic [NCH*ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [NCH*DATA_W-1:0] data_mem_r [DEPTH];

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic [NCH-1:0] filt_we_s;
  logic           push_hs_s;
  logic           store_s;
  logic           pop_s;

  assign mem_ready = (count_r != CNT_FULL);
  assign wb_valid  = (count_r != {CNT_W{1'b0}});
  assign busy_out  = wb_valid;
  assign count     = count_r;

  // Handshake qualification and push-time enable filtering.
  always_comb begin
    filt_we_s = filter_we(mem_we, mem_w_addr);
    push_hs_s = mem_valid & mem_ready & rdy_in & ~flush_in;
    pop_s     = wb_valid & wb_ready & rdy_in & ~flush_in;
    if ((DROP_EMPTY != 0) && (filt_we_s == {NCH{1'b0}})) begin
      store_s = 1'b0;
    end else begin
      store_s = push_hs_s;
    end
  end

  // Head outputs read from storage, forced to zero while the queue is empty.
  always_comb begin
    wb_we     = {NCH{1'b0}};
    wb_w_addr = {(NCH*ADDR_W){1'b0}};
    wb_w_data = {(NCH*DATA_W){1'b0}};
    if (wb_valid) begin
      wb_we     = we_mem_r[rd_ptr_r];
      wb_w_addr = addr_mem_r[rd_ptr_r];
      wb_w_data = data_mem_r[rd_ptr_r];
    end else begin
      wb_we     = {NCH{1'b0}};
    end
  end

  // Queue storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk_in) begin
    if (store_s) begin
      we_mem_r[wr_ptr_r]   <= filt_we_s;
      addr_mem_r[wr_ptr_r] <= mem_w_addr;
      data_mem_r[wr_ptr_r] <= mem_w_data;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (rdy_in) begin
      if (flush_in) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (store_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        if (store_s && !pop_s) begin
          count_r <= count_r + CNT_ONE;
        end else if (pop_s && !store_s) begin
          count_r <= count_r - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_wb_buf.sv
// Directed bench for pipe_mem_wb_buf with default parameters
// (DATA_W=32, ADDR_W=5, NCH=2, DEPTH=2, DROP_EMPTY=1, ZERO_REG=1).
module tb_pipe_mem_wb_buf;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        mem_valid;
  logic        mem_ready;
  logic [1:0]  mem_we;
  logic [9:0]  mem_w_addr;
  logic [63:0] mem_w_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_we;
  logic [9:0]  wb_w_addr;
  logic [63:0] wb_w_data;
  logic [1:0]  count;
  logic        busy_out;

  int check_cnt;
  int err_cnt;

  pipe_mem_wb_buf dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_we      (wb_we),
    .wb_w_addr  (wb_w_addr),
    .wb_w_data  (wb_w_data),
    .count      (count),
    .busy_out   (busy_out)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_push(input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
    mem_we     = we;
    mem_w_addr = {a1, a0};
    mem_w_data = {d1, d0};
  endtask

  initial begin
    check_cnt  = 0;
    err_cnt    = 0;
    rst_in     = 1'b0;
    rdy_in     = 1'b1;
    flush_in   = 1'b0;
    mem_valid  = 1'b1;
    wb_ready   = 1'b0;
    set_push(2'b01, 5'd3, 5'd0, 32'h1111_1111, 32'h0);

    // Reset state, with a push attempt held during reset.
    step();
    check_val("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check_val("rst_wb_we", {62'd0, wb_we}, 64'd0);
    check_val("rst_wb_addr", {54'd0, wb_w_addr}, 64'd0);
    check_val("rst_wb_data", wb_w_data, 64'd0);
    check_val("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
    check_val("rst_busy", {63'd0, busy_out}, 64'd0);
    check_val("rst_count", {62'd0, count}, 64'd0);
    mem_valid = 1'b0;
    step();
    rst_in = 1'b1;

    // Reset/latency: single push, no same-cycle bypass.
    set_push(2'b01, 5'd3, 5'd0, 32'hDEAD_BEEF, 32'h0);
    mem_valid = 1'b1;
    #1;
    check_val("lat_no_bypass", {63'd0, wb_valid}, 64'd0);
    step();
    mem_valid = 1'b0;
    check_val("lat_wb_valid", {63'd0, wb_valid}, 64'd1);
    check_val("lat_wb_we", {62'd0, wb_we}, 64'd1);
    check_val("lat_wb_addr", {54'd0, wb_w_addr}, 64'd3);
    check_val("lat_wb_data", wb_w_data, 64'h0000_0000_DEAD_BEEF);
    check_val("lat_count", {62'd0, count}, 64'd1);
    check_val("lat_busy", {63'd0, busy_out}, 64'd1);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check_val("lat_pop_count", {62'd0, count}, 64'd0);

    // Fill and backpressure.
    mem_valid = 1'b1;
    set_push(2'b01, 5'd1, 5'd0, 32'd1, 32'd0);
    step();
    check_val("fill1_count", {62'd0, count}, 64'd1);
    check_val("fill1_ready", {63'd0, mem_ready}, 64'd1);
    set_push(2'b01, 5'd2, 5'd0, 32'd2, 32'd0);
    step();
    check_val("fill2_count", {62'd0, count}, 64'd2);
    check_val("fill2_ready", {63'd0, mem_ready}, 64'd0);
    set_push(2'b01, 5'd3, 5'd0, 32'd3, 32'd0);
    step();
    check_val("fill3_count", {62'd0, count}, 64'd2);
    check_val("fill3_head", {32'd0, wb_w_data[31:0]}, 64'd1);
    // Full with simultaneous pop: push rejected this cycle.
    wb_ready = 1'b1;
    step();
    check_val("fullpop_count", {62'd0, count}, 64'd1);
    check_val("fullpop_head", {32'd0, wb_w_data[31:0]}, 64'd2);
    step();
    check_val("pushpop_count", {62'd0, count}, 64'd1);
    check_val("pushpop_head", {32'd0, wb_w_data[31:0]}, 64'd3);
    check_val("pushpop_addr", {54'd0, wb_w_addr}, 64'd3);
    mem_valid = 1'b0;
    step();
    check_val("drain_count", {62'd0, count}, 64'd0);

    // Streaming push+pop over 8 entries exercises pointer wrap.
    mem_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_push(2'b01, 5'(10 + k), 5'd0, 32'(32'h100 + k), 32'd0);
      step();
      check_val("wrap_head", {32'd0, wb_w_data[31:0]}, 64'(32'h100 + k));
      check_val("wrap_count", {62'd0, count}, 64'd1);
    end
    mem_valid = 1'b0;
    step();
    wb_ready = 1'b0;
    check_val("wrap_drain", {62'd0, count}, 64'd0);

    // Filtering: same-index conflict, highest channel keeps its enable.
    mem_valid = 1'b1;
    set_push(2'b11, 5'd7, 5'd7, 32'hA, 32'hB);
    step();
    mem_valid = 1'b0;
    check_val("conf_we", {62'd0, wb_we}, 64'd2);
    check_val("conf_data1", {32'd0, wb_w_data[63:32]}, 64'hB);
    check_val("conf_data0", {32'd0, wb_w_data[31:0]}, 64'hA);
    check_val("conf_addr", {54'd0, wb_w_addr}, {54'd0, 5'd7, 5'd7});
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    // Distinct indices keep both enables; x0 on channel 0 clears only it.
    mem_valid = 1'b1;
    set_push(2'b11, 5'd4, 5'd9, 32'h1, 32'h2);
    step();
    check_val("nconf_we", {62'd0, wb_we}, 64'd3);
    set_push(2'b11, 5'd0, 5'd5, 32'h3, 32'h4);
    wb_ready = 1'b1;
    step();
    mem_valid = 1'b0;
    check_val("x0_we", {62'd0, wb_we}, 64'd2);
    step();
    wb_ready = 1'b0;
    check_val("x0_drain", {62'd0, count}, 64'd0);
    // Entry writing only x0 is consumed but dropped.
    mem_valid = 1'b1;
    set_push(2'b01, 5'd0, 5'd0, 32'h5, 32'h0);
    #1;
    check_val("drop_ready", {63'd0, mem_ready}, 64'd1);
    step();
    mem_valid = 1'b0;
    check_val("drop_count", {62'd0, count}, 64'd0);
    check_val("drop_valid", {63'd0, wb_valid}, 64'd0);

    // Flush priority at count=2 and at count=1 (where a push could land).
    mem_valid = 1'b1;
    set_push(2'b01, 5'd1, 5'd0, 32'h21, 32'h0);
    step();
    step();
    check_val("flush_pre", {62'd0, count}, 64'd2);
    flush_in = 1'b1;
    wb_ready = 1'b1;
    step();
    flush_in = 1'b0;
    mem_valid = 1'b0;
    wb_ready = 1'b0;
    check_val("flush_count", {62'd0, count}, 64'd0);
    check_val("flush_valid", {63'd0, wb_valid}, 64'd0);
    check_val("flush_we", {62'd0, wb_we}, 64'd0);
    check_val("flush_addr", {54'd0, wb_w_addr}, 64'd0);
    check_val("flush_data", wb_w_data, 64'd0);
    check_val("flush_ready", {63'd0, mem_ready}, 64'd1);
    mem_valid = 1'b1;
    step();
    check_val("flush1_pre", {62'd0, count}, 64'd1);
    flush_in = 1'b1;
    wb_ready = 1'b1;
    step();
    flush_in = 1'b0;
    mem_valid = 1'b0;
    wb_ready = 1'b0;
    check_val("flush1_count", {62'd0, count}, 64'd0);

    // rdy_in freeze ignores push, pop and flush.
    mem_valid = 1'b1;
    set_push(2'b01, 5'd5, 5'd0, 32'h55, 32'h0);
    step();
    rdy_in    = 1'b0;
    flush_in  = 1'b1;
    wb_ready  = 1'b1;
    set_push(2'b01, 5'd6, 5'd0, 32'h66, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("frz_count", {62'd0, count}, 64'd1);
      check_val("frz_head", {32'd0, wb_w_data[31:0]}, 64'h55);
      check_val("frz_ready", {63'd0, mem_ready}, 64'd1);
    end
    // Pointers held: next push lands behind the frozen head.
    rdy_in   = 1'b1;
    flush_in = 1'b0;
    wb_ready = 1'b0;
    step();
    mem_valid = 1'b0;
    check_val("frz_after_count", {62'd0, count}, 64'd2);
    check_val("frz_after_head", {32'd0, wb_w_data[31:0]}, 64'h55);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check_val("frz_second", {32'd0, wb_w_data[31:0]}, 64'h66);

    // Asynchronous reset during a freeze clears without a clock edge.
    rdy_in = 1'b0;
    step();
    #1;
    rst_in = 1'b0;
    #1;
    check_val("arst_count", {62'd0, count}, 64'd0);
    check_val("arst_valid", {63'd0, wb_valid}, 64'd0);
    check_val("arst_data", wb_w_data, 64'd0);
    check_val("arst_ready", {63'd0, mem_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
